// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl sequencer: opcodes, FSM states,
// instruction classes, ALU function codes and register-file write sources.
package cpu_pkg;

  localparam int unsigned OPC_W           = 4;
  localparam int unsigned ALU_W           = 3;
  localparam int unsigned WSEL_W          = 2;
  localparam int unsigned RET_W           = 16;
  localparam int unsigned MEM_TIMEOUT_DEF = 15;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OPC_OR   = 4'h4;
  localparam logic [OPC_W-1:0] OPC_LDI  = 4'h5;
  localparam logic [OPC_W-1:0] OPC_LD   = 4'h6;
  localparam logic [OPC_W-1:0] OPC_ST   = 4'h7;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'h8;
  localparam logic [OPC_W-1:0] OPC_BRZ  = 4'h9;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;

  localparam logic [WSEL_W-1:0] WSEL_ALU = 2'd0;
  localparam logic [WSEL_W-1:0] WSEL_IMM = 2'd1;
  localparam logic [WSEL_W-1:0] WSEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT,
    ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LDI,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_BRZ,
    CLS_HALT
  } iclass_e;

endpackage

// File: rtl/cpu_ctrl_dec.sv
// Opcode decoder: maps the IR opcode field to an instruction class and ALU function.
module cpu_ctrl_dec
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output iclass_e          iclass_c,
  output logic [ALU_W-1:0] alu_op_c
);

  // Unassigned codes fall through to NOP.
  always_comb begin
    iclass_c = CLS_NOP;
    alu_op_c = ALU_ADD;
    case (opcode)
      OPC_NOP:  iclass_c = CLS_NOP;
      OPC_ADD:  begin iclass_c = CLS_ALU; alu_op_c = ALU_ADD; end
      OPC_SUB:  begin iclass_c = CLS_ALU; alu_op_c = ALU_SUB; end
      OPC_AND:  begin iclass_c = CLS_ALU; alu_op_c = ALU_AND; end
      OPC_OR:   begin iclass_c = CLS_ALU; alu_op_c = ALU_OR;  end
      OPC_LDI:  iclass_c = CLS_LDI;
      OPC_LD:   iclass_c = CLS_LD;
      OPC_ST:   iclass_c = CLS_ST;
      OPC_JMP:  iclass_c = CLS_JMP;
      OPC_BRZ:  iclass_c = CLS_BRZ;
      OPC_HALT: iclass_c = CLS_HALT;
      default:  iclass_c = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute FSM with memory
// wait timeout and a retired-instruction counter.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              zero,
  input  logic              mem_ack,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              jmp,
  output logic              br,
  output logic [ALU_W-1:0]  alu_op,
  output logic              rf_we,
  output logic [WSEL_W-1:0] rf_wsel,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_asel,
  output logic              halted,
  output logic              fault,
  output logic [RET_W-1:0]  retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [RET_W-1:0]  retired_q, retired_d;
  logic              timeout;
  iclass_e           iclass;
  logic [ALU_W-1:0]  dec_alu_op;

  cpu_ctrl_dec u_dec (
    .opcode   (opcode),
    .iclass_c (iclass),
    .alu_op_c (dec_alu_op)
  );

  assign wait_inc = wait_q + WAIT_W'(1);
  assign timeout  = (wait_inc == WAIT_W'(MEM_TIMEOUT));
  assign retired  = retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next state, counters and per-state control outputs.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    jmp       = 1'b0;
    br        = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    rf_wsel   = WSEL_ALU;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_asel  = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else begin
          wait_d = wait_inc;
          if (timeout) state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        case (iclass)
          CLS_JMP:         begin jmp = 1'b1; state_d = ST_FETCH; end
          CLS_BRZ:         begin br = zero;  state_d = ST_FETCH; end
          CLS_HALT:        state_d = ST_HALT;
          CLS_ALU, CLS_LDI: state_d = ST_EXEC;
          CLS_LD, CLS_ST:  state_d = ST_MEM;
          default:         state_d = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        rf_we   = 1'b1;
        alu_op  = dec_alu_op;
        if (iclass == CLS_LDI) rf_wsel = WSEL_IMM;
        state_d = ST_FETCH;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_asel = 1'b1;
        mem_we   = (iclass == CLS_ST);
        if (mem_ack) begin
          if (iclass == CLS_LD) begin
            rf_we   = 1'b1;
            rf_wsel = WSEL_MEM;
          end
          state_d = ST_FETCH;
        end else begin
          wait_d = wait_inc;
          if (timeout) state_d = ST_FAULT;
        end
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  state_d = ST_IDLE;
    endcase

    // Fresh wait budget for every new memory access.
    if ((state_d == ST_FETCH || state_d == ST_MEM) && state_d != state_q)
      wait_d = '0;

    if (state_d == ST_FETCH &&
        (state_q == ST_DECODE || state_q == ST_EXEC || state_q == ST_MEM))
      retired_d = retired_q + RET_W'(1);
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction-level reference model expands
// each instruction into its expected per-cycle control trace.
module tb_cpu_ctrl;

  localparam int unsigned TO = 15;

  logic        clk, rst_n, run, zero, mem_ack;
  logic [3:0]  opcode;
  logic        ir_load, pc_inc, jmp, br, rf_we, mem_req, mem_we, mem_asel, halted, fault;
  logic [2:0]  alu_op;
  logic [1:0]  rf_wsel;
  logic [15:0] retired;

  cpu_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ack(mem_ack), .ir_load(ir_load), .pc_inc(pc_inc), .jmp(jmp), .br(br),
    .alu_op(alu_op), .rf_we(rf_we), .rf_wsel(rf_wsel), .mem_req(mem_req),
    .mem_we(mem_we), .mem_asel(mem_asel), .halted(halted), .fault(fault),
    .retired(retired)
  );

  typedef struct packed {
    logic       ir_load, pc_inc, jmp, br;
    logic [2:0] alu_op;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic       mem_req, mem_we, mem_asel, halted, fault;
  } outs_t;

  typedef struct {
    logic        run;
    logic [3:0]  opc;
    logic        z;
    logic        ack;
    outs_t       exp;
    logic [15:0] ret;
  } cyc_t;

  cyc_t        trace[$];
  logic [15:0] m_ret;
  int          n_tests = 0;
  int          n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(input logic r, input logic [3:0] o, input logic z,
                               input logic a, input outs_t e);
    cyc_t c;
    c.run = r; c.opc = o; c.z = z; c.ack = a; c.exp = e; c.ret = m_ret;
    trace.push_back(c);
  endfunction

  function automatic void add_idle(input logic r);
    push(r, 4'($urandom), rb(), rb(), '0);
  endfunction

  // Instruction fetch: fw cycles of waiting, then the acknowledged cycle.
  function automatic void add_fetch(input int fw);
    outs_t e;
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < fw; i++) push(rb(), 4'($urandom), rb(), 1'b0, e);
    e.ir_load = 1'b1; e.pc_inc = 1'b1;
    push(rb(), 4'($urandom), rb(), 1'b1, e);
  endfunction

  function automatic outs_t mem_outs(input logic [3:0] opc);
    outs_t e;
    e = '0; e.mem_req = 1'b1; e.mem_asel = 1'b1; e.mem_we = (opc == 4'h7);
    return e;
  endfunction

  function automatic void add_instr(input logic [3:0] opc, input int fw,
                                    input int mw, input logic z);
    outs_t e;
    add_fetch(fw);
    e = '0;
    if (opc == 4'h8) e.jmp = 1'b1;
    if (opc == 4'h9) e.br = z;
    push(rb(), opc, z, rb(), e);
    if (opc >= 4'h1 && opc <= 4'h5) begin
      e = '0; e.rf_we = 1'b1;
      if (opc == 4'h5) e.rf_wsel = 2'd1;
      else             e.alu_op  = 3'(opc - 4'h1);
      push(rb(), opc, rb(), rb(), e);
    end else if (opc == 4'h6 || opc == 4'h7) begin
      e = mem_outs(opc);
      for (int i = 0; i < mw; i++) push(rb(), opc, rb(), 1'b0, e);
      if (opc == 4'h6) begin e.rf_we = 1'b1; e.rf_wsel = 2'd2; end
      push(rb(), opc, rb(), 1'b1, e);
    end
    if (opc != 4'hF) m_ret = m_ret + 16'd1;
  endfunction

  function automatic void add_absorb(input int n, input logic is_halt);
    outs_t e;
    e = '0;
    if (is_halt) e.halted = 1'b1;
    else         e.fault  = 1'b1;
    for (int i = 0; i < n; i++) push(rb(), 4'($urandom), rb(), rb(), e);
  endfunction

  function automatic void add_fetch_timeout();
    outs_t e;
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < TO; i++) push(rb(), 4'($urandom), rb(), 1'b0, e);
    add_absorb(6, 1'b0);
  endfunction

  function automatic void add_mem_timeout(input logic [3:0] opc);
    add_fetch(0);
    push(rb(), opc, rb(), rb(), '0);
    for (int i = 0; i < TO; i++) push(rb(), opc, rb(), 1'b0, mem_outs(opc));
    add_absorb(6, 1'b0);
  endfunction

  task automatic drive_cycle(input cyc_t c, output outs_t o, output logic [15:0] r);
    @(negedge clk);
    run = c.run; opcode = c.opc; zero = c.z; mem_ack = c.ack;
    #1;
    o = {ir_load, pc_inc, jmp, br, alu_op, rf_we, rf_wsel,
         mem_req, mem_we, mem_asel, halted, fault};
    r = retired;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = rb(); opcode = 4'($urandom); zero = rb(); mem_ack = rb();
    @(posedge clk);
    #1;
    rst_n = 1'b1; run = 1'b0;
    m_ret = 16'd0;
    trace.delete();
  endtask

  task automatic test_reset();
    outs_t o; logic [15:0] r;
    do_reset();
    for (int i = 0; i < 4; i++) add_idle(1'b0);
    foreach (trace[i]) begin
      drive_cycle(trace[i], o, r);
      n_tests++;
      if (o !== trace[i].exp || r !== trace[i].ret) begin
        n_fail++;
        $display("FAIL reset[%0d] out=%h ret=%h want out=%h ret=%h", i, o, r, trace[i].exp, trace[i].ret);
      end
    end
  endtask

  task automatic test_add_loop();
    outs_t o; logic [15:0] r; int n_exec = 0;
    do_reset();
    add_idle(1'b1);
    for (int k = 0; k < 4; k++) add_instr(4'h1, 0, 0, 1'b0);
    foreach (trace[i]) begin
      drive_cycle(trace[i], o, r);
      n_tests++;
      if (o !== trace[i].exp || r !== trace[i].ret) begin
        n_fail++;
        $display("FAIL add_loop[%0d] out=%h ret=%h want out=%h ret=%h", i, o, r, trace[i].exp, trace[i].ret);
      end
      if (o.rf_we && o.alu_op == 3'd0) n_exec++;
      if (i == 10 && r !== 16'd3) begin
        n_fail++;
        $display("FAIL add_loop_retired got=%0d want=3", r);
      end
    end
    n_tests++;
    if (n_exec !== 4) begin
      n_fail++;
      $display("FAIL add_loop_exec_count got=%0d want=4", n_exec);
    end
  endtask

  task automatic test_branch();
    outs_t o; logic [15:0] r; int n_br = 0;
    do_reset();
    add_idle(1'b1);
    add_instr(4'h9, 0, 0, 1'b1);
    add_instr(4'h9, 1, 0, 1'b0);
    add_instr(4'h8, 0, 0, rb());
    add_instr(4'h0, 2, 0, rb());
    add_instr(4'hC, 0, 0, rb());
    add_instr(4'h0, 0, 0, rb());
    foreach (trace[i]) begin
      drive_cycle(trace[i], o, r);
      n_tests++;
      if (o !== trace[i].exp || r !== trace[i].ret) begin
        n_fail++;
        $display("FAIL branch[%0d] out=%h ret=%h want out=%h ret=%h", i, o, r, trace[i].exp, trace[i].ret);
      end
      if (o.br) n_br++;
    end
    n_tests++;
    if (n_br !== 1) begin
      n_fail++;
      $display("FAIL branch_br_cycles got=%0d want=1", n_br);
    end
  endtask

  task automatic test_mem_wait();
    outs_t o; logic [15:0] r; int n_asel = 0, n_ldw = 0;
    do_reset();
    add_idle(1'b1);
    add_instr(4'h6, 0, 4, 1'b0);
    add_instr(4'h7, 2, 1, 1'b0);
    add_instr(4'h5, 0, 0, 1'b0);
    add_instr(4'h0, 0, 0, 1'b0);
    foreach (trace[i]) begin
      drive_cycle(trace[i], o, r);
      n_tests++;
      if (o !== trace[i].exp || r !== trace[i].ret) begin
        n_fail++;
        $display("FAIL mem_wait[%0d] out=%h ret=%h want out=%h ret=%h", i, o, r, trace[i].exp, trace[i].ret);
      end
      if (o.mem_asel) n_asel++;
      if (o.rf_we && o.rf_wsel == 2'd2) n_ldw++;
    end
    n_tests++;
    if (n_asel !== 7 || n_ldw !== 1) begin
      n_fail++;
      $display("FAIL mem_wait_counts asel=%0d ldw=%0d want 7 and 1", n_asel, n_ldw);
    end
  endtask

  task automatic test_timeout();
    outs_t o; logic [15:0] r;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      add_idle(1'b1);
      if (pass == 0) begin
        add_instr(4'h0, TO - 1, 0, 1'b0);
        add_instr(4'h6, 0, TO - 1, 1'b0);
        add_instr(4'h7, 0, TO - 1, 1'b0);
        add_fetch_timeout();
      end else begin
        add_instr(4'h2, 0, 0, 1'b0);
        add_mem_timeout(4'h6);
      end
      foreach (trace[i]) begin
        drive_cycle(trace[i], o, r);
        n_tests++;
        if (o !== trace[i].exp || r !== trace[i].ret) begin
          n_fail++;
          $display("FAIL timeout%0d[%0d] out=%h ret=%h want out=%h ret=%h", pass, i, o, r, trace[i].exp, trace[i].ret);
        end
      end
    end
  endtask

  task automatic test_halt();
    outs_t o; logic [15:0] r;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        do_reset();
        add_idle(1'b1);
        add_instr(4'h3, 0, 0, 1'b0);
        add_instr(4'hF, 1, 0, 1'b0);
        add_absorb(20, 1'b1);
      end else begin
        do_reset();
        add_idle(1'b0);
        add_idle(1'b0);
      end
      foreach (trace[i]) begin
        drive_cycle(trace[i], o, r);
        n_tests++;
        if (o !== trace[i].exp || r !== trace[i].ret) begin
          n_fail++;
          $display("FAIL halt%0d[%0d] out=%h ret=%h want out=%h ret=%h", pass, i, o, r, trace[i].exp, trace[i].ret);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    outs_t o; logic [15:0] r; outs_t e;
    do_reset();
    add_idle(1'b1);
    add_instr(4'h4, 0, 0, 1'b0);
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) push(rb(), 4'($urandom), rb(), 1'b0, e);
    foreach (trace[i]) begin
      drive_cycle(trace[i], o, r);
      n_tests++;
      if (o !== trace[i].exp || r !== trace[i].ret) begin
        n_fail++;
        $display("FAIL reset_mid_pre[%0d] out=%h ret=%h want out=%h ret=%h", i, o, r, trace[i].exp, trace[i].ret);
      end
    end
    do_reset();
    add_idle(1'b0);
    foreach (trace[i]) begin
      drive_cycle(trace[i], o, r);
      n_tests++;
      if (o !== 15'd0 || r !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_mid_post out=%h ret=%h want 0", o, r);
      end
    end
  endtask

  task automatic test_random();
    outs_t o; logic [15:0] r; int fw, mw;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      add_idle(1'b1);
      for (int k = 0; k < 40; k++) begin
        fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
        mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
        add_instr(4'($urandom_range(0, 14)), fw, mw, rb());
      end
      case (round)
        0: begin add_instr(4'hF, 0, 0, 1'b0); add_absorb(10, 1'b1); end
        1: add_fetch_timeout();
        2: add_mem_timeout(4'h7);
        default: add_instr(4'h0, 0, 0, 1'b0);
      endcase
      foreach (trace[i]) begin
        drive_cycle(trace[i], o, r);
        n_tests++;
        if (o !== trace[i].exp || r !== trace[i].ret) begin
          n_fail++;
          $display("FAIL random%0d[%0d] out=%h ret=%h want out=%h ret=%h", round, i, o, r, trace[i].exp, trace[i].ret);
        end
      end
    end
  endtask

  task automatic test_wrap();
    outs_t o; logic [15:0] r;
    do_reset();
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    m_ret = 16'hFFFE;
    add_idle(1'b1);
    for (int k = 0; k < 4; k++) add_instr(4'h0, 0, 0, 1'b0);
    foreach (trace[i]) begin
      drive_cycle(trace[i], o, r);
      n_tests++;
      if (o !== trace[i].exp || r !== trace[i].ret) begin
        n_fail++;
        $display("FAIL wrap[%0d] out=%h ret=%h want out=%h ret=%h", i, o, r, trace[i].exp, trace[i].ret);
      end
    end
    n_tests++;
    if (r !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_final retired=%h want 0001", r);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ack = 1'b0;
    m_ret = 16'd0;
    repeat (3) @(posedge clk);
    test_reset();
    test_add_loop();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_reset_mid_access();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum cycles to wait for mem_ack before fault.
REQ-002 Ports, in order:
  - clk  in  1  single clock; all state updates on posedge.
  - rst_n  in  1  synchronous, active-low reset.
  - run  in  1  leave IDLE and start fetching.
  - opcode  in  4  IR bits [15:12], valid from the DECODE cycle onward.
  - zero  in  1  ALU zero flag.
  - mem_ack  in  1  memory completes the current request this cycle.
  - ir_load  out  1  IR captures memory data.
  - pc_inc  out  1  PC increments.
  - jmp  out  1  PC loads disp unconditionally.
  - br  out  1  PC loads PC+disp.
  - alu_op  out  3  ALU function.
  - rf_we  out  1  register-file write enable.
  - rf_wsel  out  2  write source: 0 ALU, 1 imm, 2 mem.
  - mem_req  out  1  memory request.
  - mem_we  out  1  store.
  - mem_asel  out  1  address source: 0 PC, 1 reg[addr_b].
  - halted  out  1  in HALT.
  - fault  out  1  in FAULT.
  - retired  out  16  count of completed instructions.

Function
REQ-003 States: IDLE, FETCH, DECODE, EXEC, MEM, HALT, FAULT; all outputs are combinational from state, opcode, zero and mem_ack; unlisted outputs are 0.
REQ-004 IDLE -> FETCH when run=1, else stay in IDLE.
REQ-005 FETCH: mem_req=1, mem_asel=0; in the mem_ack=1 cycle also ir_load=1 and pc_inc=1, and the next state is DECODE.
REQ-006 Opcode map:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR (alu_op = opcode-1)
  - 5 LDI, 6 LD, 7 ST
  - 8 JMP, 9 BRZ
  - F HALT
  - any other code executes as NOP.
REQ-007 DECODE, one cycle:
  - JMP: jmp=1, next FETCH.
  - BRZ: br=zero, next FETCH.
  - NOP: next FETCH.
  - HALT: next HALT.
  - ALU or LDI: next EXEC.
  - LD or ST: next MEM.
REQ-008 EXEC, one cycle: rf_we=1; rf_wsel=1 for LDI, 0 otherwise with alu_op per REQ-006; next FETCH.
REQ-009 MEM: mem_req=1, mem_asel=1, mem_we=1 for ST; in the mem_ack=1 cycle LD also drives rf_we=1 and rf_wsel=2; next FETCH on mem_ack.
REQ-010 Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle mem_ack=0; reaching MEM_TIMEOUT goes to FAULT.
REQ-011 mem_ack arriving in the same cycle the counter reaches MEM_TIMEOUT is accepted; no fault results.
REQ-012 HALT and FAULT are absorbing; only reset leaves them; no memory or register writes occur while in either state.
REQ-013 retired increments by 1 on each transition into FETCH from DECODE, EXEC or MEM; it wraps FFFF->0000.
REQ-014 Instruction latency, counted from FETCH acknowledge:
  - JMP, BRZ, NOP: 2 cycles.
  - ALU, LDI: 3 cycles.
  - LD, ST: 3 cycles plus memory wait.
REQ-015 jmp and br are never asserted in the same cycle, and neither is asserted together with pc_inc.

Reset
REQ-016 With rst_n=0 at posedge: state=IDLE, wait counter=0, retired=0; all outputs read 0 in the following cycle.
REQ-017 Reset mid-operation, including while mem_req is held, abandons the access; mem_req is 0 in the cycle after the reset edge.

Structure
REQ-018 Shared package cpu_pkg holds:
  - opcode constants
  - state enumeration
  - alu_op codes
  - rf_wsel codes
  - default MEM_TIMEOUT.
REQ-019 One sub-module, cpu_ctrl_dec, maps opcode to instruction class and alu_op combinationally; the FSM, counters and output logic stay in cpu_ctrl.

Verification
REQ-020 Reset then run=1 with mem_ack=1 every cycle and opcode=1 (ADD): expect FETCH, DECODE, EXEC repeating; rf_we=1 in EXEC with alu_op=0; retired=3 after 9 cycles.
REQ-021 opcode=9 (BRZ) with zero=1: br=1 for exactly 1 cycle in DECODE. Repeat with zero=0: br stays 0 and retired still increments.
REQ-022 LD with mem_ack delayed 4 cycles in MEM: mem_req, mem_asel=1 held 5 cycles; rf_we=1 with rf_wsel=2 only in the ack cycle.
REQ-023 mem_ack withheld in FETCH: fault=1 after 15 cycles. Repeat with ack in cycle 15: no fault, DECODE follows.
REQ-024 opcode=F: halted=1 and stays 1 for 20 cycles under any stimulus; rst_n=0 then returns to IDLE with all outputs 0.
REQ-025 retired preloaded near wrap through 65537 NOPs: retired reads 0001.
